pwm_shadow_loader: RTL and testbench

Double-buffered configuration scheduler for the 8-carrier 16-bit PWM array. A single bus-side requester writes per-channel shadow registers (period, compare, initial carrier, dead times) through a valid/ready port. The requester then arms a set of channels. Each armed channel copies its shadow registers into the active registers on the next rising edge of that channel's maskevent, so a carrier never sees a mid-period register change. Sits between the AXI register file and the packed period_x / compare_x / initcarr_x / dtime_A_x / dtime_B_x inputs of the PWM core.

---
 rtl/pwm_shadow_loader.sv | 115 +++++++++++
 tb/tb_pwm_shadow_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_loader.sv
// pwm_shadow_loader: double-buffered per-channel PWM config, shadow -> active on armed maskevent rising edge.
// Optional macro PWMSHADOW_FORCE_EN adds force_load to load every armed channel at once.
module pwm_shadow_loader #(
    parameter int PWM_WIDTH      = 8,
    parameter int PWMCOUNT_WIDTH = 16,
    parameter int DTCOUNT_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [$clog2(PWM_WIDTH)-1:0]        wr_chan,
    input  logic [1:0]                          wr_sel,
    input  logic [PWMCOUNT_WIDTH-1:0]           wr_data,
    input  logic                                commit_valid,
    input  logic [PWM_WIDTH-1:0]                commit_mask,
    output logic                                commit_ready,
    input  logic [PWM_WIDTH-1:0]                maskevent_x,
`ifdef PWMSHADOW_FORCE_EN
    input  logic                                force_load,
`endif
    output logic [PWM_WIDTH*PWMCOUNT_WIDTH-1:0] period_x,
    output logic [PWM_WIDTH*PWMCOUNT_WIDTH-1:0] compare_x,
    output logic [PWM_WIDTH*PWMCOUNT_WIDTH-1:0] initcarr_x,
    output logic [PWM_WIDTH*DTCOUNT_WIDTH-1:0]  dtime_A_x,
    output logic [PWM_WIDTH*DTCOUNT_WIDTH-1:0]  dtime_B_x,
    output logic [PWM_WIDTH-1:0]                pending,
    output logic [PWM_WIDTH-1:0]                load_done
);
    localparam int CW = $clog2(PWM_WIDTH);
    localparam int PC = PWMCOUNT_WIDTH;
    localparam int DT = DTCOUNT_WIDTH;

    typedef enum logic {IDLE, ARMED} state_t;

    logic [PWM_WIDTH-1:0] ev_prev, rise;
    logic                 wr_fire, commit_fire, frc;

`ifdef PWMSHADOW_FORCE_EN
    assign frc = force_load;
`else
    assign frc = 1'b0;
`endif

    // Handshakes are held low while reset is asserted.
    assign commit_ready = reset;
    assign wr_ready     = reset && !pending[wr_chan];
    assign wr_fire      = wr_valid && wr_ready;
    assign commit_fire  = commit_valid && commit_ready;
    assign rise         = maskevent_x & ~ev_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ev_prev <= '0;
        else        ev_prev <= maskevent_x;
    end

    for (genvar g = 0; g < PWM_WIDTH; g++) begin : ch
        state_t        state_q, state_d;
        logic [PC-1:0] sh_period, sh_compare, sh_initcarr;
        logic [PC-1:0] act_period, act_compare, act_initcarr;
        logic [DT-1:0] sh_dta, sh_dtb, act_dta, act_dtb;
        logic          wr_hit, load, done_q;

        assign wr_hit = wr_fire && wr_chan == CW'(g);
        assign load   = state_q == ARMED && (rise[g] || frc);

        // Armed channels ignore commit bits; an idle channel never loads in its arming cycle.
        always_comb begin
            state_d = (state_q == ARMED) ? (load ? IDLE : ARMED)
                                         : ((commit_fire && commit_mask[g]) ? ARMED : IDLE);
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q      <= IDLE;
                done_q       <= 1'b0;
                sh_period    <= '0;
                sh_compare   <= '0;
                sh_initcarr  <= '0;
                sh_dta       <= '0;
                sh_dtb       <= '0;
                act_period   <= '0;
                act_compare  <= '0;
                act_initcarr <= '0;
                act_dta      <= '0;
                act_dtb      <= '0;
            end else begin
                state_q <= state_d;
                done_q  <= load;
                if (wr_hit && wr_sel == 2'd0) sh_period   <= wr_data;
                if (wr_hit && wr_sel == 2'd1) sh_compare  <= wr_data;
                if (wr_hit && wr_sel == 2'd2) sh_initcarr <= wr_data;
                if (wr_hit && wr_sel == 2'd3) begin
                    sh_dta <= wr_data[DT-1:0];
                    sh_dtb <= wr_data[2*DT-1:DT];
                end
                if (load) begin
                    act_period   <= sh_period;
                    act_compare  <= sh_compare;
                    act_initcarr <= sh_initcarr;
                    act_dta      <= sh_dta;
                    act_dtb      <= sh_dtb;
                end
            end
        end

        assign pending[g]              = state_q == ARMED;
        assign load_done[g]            = done_q;
        assign period_x[PC*g +: PC]    = act_period;
        assign compare_x[PC*g +: PC]   = act_compare;
        assign initcarr_x[PC*g +: PC]  = act_initcarr;
        assign dtime_A_x[DT*g +: DT]   = act_dta;
        assign dtime_B_x[DT*g +: DT]   = act_dtb;
    end
endmodule

// File: tb/tb_pwm_shadow_loader.sv
// tb_pwm_shadow_loader: directed bench for pwm_shadow_loader with hand-computed expectations.
module tb_pwm_shadow_loader;
    logic         clk = 0, reset = 0;
    logic         wr_valid = 0, wr_ready;
    logic [2:0]   wr_chan = 0;
    logic [1:0]   wr_sel = 0;
    logic [15:0]  wr_data = 0;
    logic         commit_valid = 0, commit_ready;
    logic [7:0]   commit_mask = 0, maskevent_x = 0, pending, load_done;
    logic [127:0] period_x, compare_x, initcarr_x;
    logic [63:0]  dtime_A_x, dtime_B_x;
`ifdef PWMSHADOW_FORCE_EN
    logic         force_load = 0;
`endif
    int checks = 0, failures = 0;

    pwm_shadow_loader dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit_valid(commit_valid), .commit_mask(commit_mask), .commit_ready(commit_ready),
        .maskevent_x(maskevent_x),
`ifdef PWMSHADOW_FORCE_EN
        .force_load(force_load),
`endif
        .period_x(period_x), .compare_x(compare_x), .initcarr_x(initcarr_x),
        .dtime_A_x(dtime_A_x), .dtime_B_x(dtime_B_x),
        .pending(pending), .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_period", period_x, 0);
        chk("rst_pending", pending, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_commit_ready", commit_ready, 0);
        step(); step();
        reset = 1;
        #1;
        chk("commit_ready_on", commit_ready, 1);
        chk("wr_ready_on", wr_ready, 1);

        // period ch2 load on event edge
        wr_valid = 1; wr_chan = 2; wr_sel = 0; wr_data = 16'h1388;
        step(); wr_valid = 0;
        commit_valid = 1; commit_mask = 8'h04;
        step(); commit_valid = 0;
        chk("t1_pending_armed", pending, 8'h04);
        chk("t1_period_before", period_x[47:32], 0);
        maskevent_x = 8'h04;
        step();
        chk("t1_load_done", load_done, 8'h04);
        chk("t1_period", period_x[47:32], 16'h1388);
        chk("t1_pending_clear", pending, 0);
        step();
        chk("t1_load_done_pulse", load_done, 0);
        // held-high event does not retrigger
        commit_valid = 1; commit_mask = 8'h04;
        step(); commit_valid = 0;
        step(); step();
        chk("held_high_pending", pending, 8'h04);
        chk("held_high_no_load", load_done, 0);
        maskevent_x = 0; step();
        maskevent_x = 8'h04; step();
        chk("held_high_new_edge", load_done, 8'h04);
        maskevent_x = 0; step();

        // idle channel write never reaches active
        wr_valid = 1; wr_chan = 0; wr_sel = 1; wr_data = 16'h0200;
        step(); wr_valid = 0;
        maskevent_x = 8'h01; step();
        chk("t2_no_load", load_done, 0);
        maskevent_x = 0; step();
        chk("t2_compare", compare_x[15:0], 0);

        // writes to armed ch5 stall, ch1 proceeds
        commit_valid = 1; commit_mask = 8'h20;
        step(); commit_valid = 0;
        wr_valid = 1; wr_chan = 5; wr_sel = 1; wr_data = 16'h0555;
        #1 chk("t3_stall", wr_ready, 0);
        step(); step();
        chk("t3_stall_hold", wr_ready, 0);
        wr_chan = 1; wr_data = 16'h1111;
        #1 chk("t3_other_ready", wr_ready, 1);
        step();
        wr_chan = 5; wr_data = 16'h0555;
        #1 chk("t3_stall_again", wr_ready, 0);
        maskevent_x = 8'h20; step();
        chk("t3_load_done", load_done, 8'h20);
        chk("t3_ready_after_load", wr_ready, 1);
        step(); wr_valid = 0; maskevent_x = 0;
        chk("t3_compare5", compare_x[95:80], 0);
        chk("t3_compare1", compare_x[31:16], 0);

        // write and commit same cycle on ch4
        wr_valid = 1; wr_chan = 4; wr_sel = 0; wr_data = 16'h0ABC;
        commit_valid = 1; commit_mask = 8'h10;
        #1 chk("t6_wr_ready", wr_ready, 1);
        step(); wr_valid = 0; commit_valid = 0;
        chk("t6_pending", pending, 8'h10);
        maskevent_x = 8'h10; step();
        chk("t6_period", period_x[79:64], 16'h0ABC);
        maskevent_x = 0; step();

        // commit and edge same cycle on idle ch6: arm only
        commit_valid = 1; commit_mask = 8'h40; maskevent_x = 8'h40;
        step(); commit_valid = 0;
        chk("t7_pending", pending, 8'h40);
        chk("t7_no_load", load_done, 0);
        maskevent_x = 0; step();
        maskevent_x = 8'h40; step();
        chk("t7_load", load_done, 8'h40);
        maskevent_x = 0; step();

        // arm all, partial then remaining edges
        commit_valid = 1; commit_mask = 8'hFF;
        step(); commit_valid = 0;
        chk("t4_all_pending", pending, 8'hFF);
        maskevent_x = 8'hA5; step();
        chk("t4_load_a5", load_done, 8'hA5);
        chk("t4_pending_5a", pending, 8'h5A);
        maskevent_x = 0; step();
        chk("t4_pulse_end", load_done, 0);
        maskevent_x = 8'h5A; step();
        chk("t4_load_5a", load_done, 8'h5A);
        chk("t4_pending_0", pending, 0);
        chk("t4_compare1", compare_x[31:16], 16'h1111);
        chk("t4_compare5", compare_x[95:80], 16'h0555);
        maskevent_x = 0; step();

        // dtime ch7 then reset mid-arm
        wr_valid = 1; wr_chan = 7; wr_sel = 3; wr_data = 16'h1A0C;
        step(); wr_valid = 0;
        commit_valid = 1; commit_mask = 8'h80;
        step(); commit_valid = 0;
        maskevent_x = 8'h80; step();
        chk("t5_dta", dtime_A_x[63:56], 8'h0C);
        chk("t5_dtb", dtime_B_x[63:56], 8'h1A);
        maskevent_x = 0; step();
        commit_valid = 1; commit_mask = 8'h80;
        step(); commit_valid = 0;
        chk("t5_rearmed", pending, 8'h80);
        #2 reset = 0;
        #1;
        chk("t5_rst_dta", dtime_A_x, 0);
        chk("t5_rst_period", period_x, 0);
        chk("t5_rst_pending", pending, 0);
        chk("t5_rst_wr_ready", wr_ready, 0);
        step(); reset = 1;
        step();
        maskevent_x = 8'h80; step();
        chk("t5_post_rst_no_load", load_done, 0);
        chk("t5_post_rst_dtb", dtime_B_x, 0);
        maskevent_x = 0; step();

`ifdef PWMSHADOW_FORCE_EN
        commit_valid = 1; commit_mask = 8'h08;
        step(); commit_valid = 0;
        force_load = 1; step(); force_load = 0;
        chk("force_load_done", load_done, 8'h08);
        chk("force_pending", pending, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
